// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: datapath width, NOP encoding, HALT opcode, fetch FSM state
// encoding and a saturating increment helper for the optional perf counters.
package fetch_pkg;

    localparam int          DATA_W      = 16;
    localparam logic [15:0] NOP_INSTR   = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of fetch-stage control inputs, memory interface and IF/ID outputs.
// Latency: n/a (wiring only).
// Backpressure: stall is carried here; the fetch unit holds state while it is high.
//
// Modports:
//   slave  - the fetch unit (consumes stall/redirect/instr_in, drives pc_out and IF/ID)
//   master - the surrounding pipeline (hazard unit, ID stage, instruction memory)
interface if_fetch_unit_if;
    import fetch_pkg::*;

    logic              stall;
    logic              br_taken;
    logic [DATA_W-1:0] br_base;
    logic [7:0]        br_offset;
    logic              jmp;
    logic [DATA_W-1:0] jmp_target;
    logic [DATA_W-1:0] instr_in;
    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] ifid_instr;
    logic [DATA_W-1:0] ifid_pc_plus1;
    logic              ifid_valid;
    logic              halted;

    modport slave (
        input  stall, br_taken, br_base, br_offset, jmp, jmp_target, instr_in,
        output pc_out, ifid_instr, ifid_pc_plus1, ifid_valid, halted
    );

    modport master (
        output stall, br_taken, br_base, br_offset, jmp, jmp_target, instr_in,
        input  pc_out, ifid_instr, ifid_pc_plus1, ifid_valid, halted
    );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: captures instruction, its PC+1 and a valid bit.
// Latency: 1 cycle from load to outputs.
// Backpressure: holds contents when neither load nor flush is asserted.
//
// Ports: clk, rst (async active-high), load, flush (flush wins over load),
// instr_d/pc_plus1_d capture data, instr_q/pc_plus1_q/valid_q registered outputs.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         flush,
    input  logic [W-1:0] instr_d,
    input  logic [W-1:0] pc_plus1_d,
    output logic [W-1:0] instr_q,
    output logic [W-1:0] pc_plus1_q,
    output logic         valid_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush) begin
            // A bubble is a NOP with zero PC+1 so downstream never sees stale data.
            instr_q    <= NOP_INSTR;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else if (load) begin
            instr_q    <= instr_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives InstructionMem, fills IF/ID.
// Latency: instr at pc_out lands in IF/ID on the next edge; redirect target on pc_out one edge after jmp/br_taken.
// Backpressure: stall freezes PC, IF/ID and FSM unless a redirect arrives on the same edge.
//
// Ports: clk, rst (async active-high), bus (if_fetch_unit_if.slave).
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt /
// perf_flush_cnt (16-bit saturating counts of captures, stall edges, redirect edges).
// Edge priority: jmp > br_taken > stall > HALT hold > normal fetch.
module if_fetch_unit #(
    parameter int          DATA_W      = fetch_pkg::DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [3:0]  HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
    input  logic clk,
    input  logic rst,
    if_fetch_unit_if.slave bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    fetch_pkg::fetch_state_e state;

    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus1;
    logic [DATA_W-1:0] br_target;
    logic              redirect;
    logic              normal;
    logic              ifid_flush;

    assign pc_plus1  = pc + DATA_W'(1);
    // Offset is a signed word count; 16-bit add wraps silently in both directions.
    assign br_target = bus.br_base + {{(DATA_W-8){bus.br_offset[7]}}, bus.br_offset};

    assign redirect   = bus.jmp | bus.br_taken;
    assign normal     = !redirect && !bus.stall && (state == fetch_pkg::RUN);
    // In HALT the first unstalled edge drops a bubble; repeating the flush keeps it there.
    assign ifid_flush = redirect || (!bus.stall && (state == fetch_pkg::HALT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= fetch_pkg::RUN;
        end else if (bus.jmp) begin
            pc    <= bus.jmp_target;
            state <= fetch_pkg::RUN;
        end else if (bus.br_taken) begin
            pc    <= br_target;
            state <= fetch_pkg::RUN;
        end else if (normal) begin
            pc <= pc_plus1;
            // The HALT instruction itself is still captured as valid this edge.
            if (bus.instr_in[DATA_W-1 -: 4] == HALT_OPCODE) begin
                state <= fetch_pkg::HALT;
            end
        end
    end

    assign bus.pc_out = pc;
    assign bus.halted = (state == fetch_pkg::HALT);

    ifid_reg #(
        .W (DATA_W)
    ) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .load       (normal),
        .flush      (ifid_flush),
        .instr_d    (bus.instr_in),
        .pc_plus1_d (pc_plus1),
        .instr_q    (bus.ifid_instr),
        .pc_plus1_q (bus.ifid_pc_plus1),
        .valid_q    (bus.ifid_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (normal)
                perf_fetch_cnt <= fetch_pkg::sat_inc(perf_fetch_cnt);
            // A stall that coincides with a redirect is overridden, so it is not counted.
            if (bus.stall && !redirect)
                perf_stall_cnt <= fetch_pkg::sat_inc(perf_stall_cnt);
            if (redirect)
                perf_flush_cnt <= fetch_pkg::sat_inc(perf_flush_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_unit_if bus();

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  rnd_mode = 1'b0;
    int  halt_addr = -1;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] pf, ps, pr;
`endif

    // Instruction memory contents. Directed mode: 16'h1000+addr, with one optional
    // HALT word at halt_addr. Random mode: every address ending in 4'hA holds a HALT.
    function automatic logic [15:0] mem_word(input logic [15:0] a, input bit rnd, input int haddr);
        if (rnd) return {(a[3:0] == 4'hA) ? 4'hF : 4'h1, a[11:0]};
        if (int'(a) == haddr) return 16'hF123;
        return 16'h1000 + a;
    endfunction

    assign bus.instr_in = mem_word(bus.pc_out, rnd_mode, halt_addr);

    if_fetch_unit #(
        .RESET_PC (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (pf),
        .perf_stall_cnt (ps),
        .perf_flush_cnt (pr)
`endif
    );

    task automatic clear_inputs();
        bus.stall      = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_base    = 16'h0000;
        bus.br_offset  = 8'h00;
        bus.jmp        = 1'b0;
        bus.jmp_target = 16'h0000;
    endtask

    // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        n_checks++;
        if ({bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid, bus.halted} !==
            {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h instr=%h pc1=%h v=%b h=%b want 0000 0000 0000 0 0",
                     bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid, bus.halted);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.instr_in !== 16'h1000) begin
            n_fail++;
            $display("FAIL mem_at_reset_pc: got instr_in=%h want 1000", bus.instr_in);
        end
    endtask

    task automatic test_free_run();
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if ({bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid} !==
                {16'(k), 16'(16'h1000 + k - 1), 16'(k), 1'b1}) begin
                n_fail++;
                $display("FAIL free_run_%0d: got pc=%h instr=%h pc1=%h v=%b want pc=%h instr=%h pc1=%h v=1",
                         k, bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid,
                         16'(k), 16'(16'h1000 + k - 1), 16'(k));
            end
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if ({bus.pc_out, bus.ifid_instr, bus.ifid_valid} !== {16'h0003, 16'h1002, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got pc=%h instr=%h v=%b want pc=0003 instr=1002 v=1",
                         k, bus.pc_out, bus.ifid_instr, bus.ifid_valid);
            end
        end
        bus.stall = 1'b0;
        tick();
        n_checks++;
        if ({bus.pc_out, bus.ifid_instr} !== {16'h0004, 16'h1003}) begin
            n_fail++;
            $display("FAIL stall_resume: got pc=%h instr=%h want pc=0004 instr=1003",
                     bus.pc_out, bus.ifid_instr);
        end
    endtask

    task automatic test_branch();
        bus.br_taken  = 1'b1;
        bus.br_base   = 16'h0005;
        bus.br_offset = 8'hFC;
        bus.stall     = 1'b1;
        tick();
        clear_inputs();
        n_checks++;
        if ({bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid} !==
            {16'h0001, 16'h0000, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL branch_flush: got pc=%h instr=%h pc1=%h v=%b want pc=0001 instr=0000 pc1=0000 v=0",
                     bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid);
        end
        tick();
        n_checks++;
        if ({bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid} !==
            {16'h0002, 16'h1001, 16'h0002, 1'b1}) begin
            n_fail++;
            $display("FAIL branch_target_fetch: got pc=%h instr=%h pc1=%h v=%b want pc=0002 instr=1001 pc1=0002 v=1",
                     bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid);
        end
    endtask

    task automatic test_jump_wrap();
        bus.jmp        = 1'b1;
        bus.jmp_target = 16'hFFFF;
        tick();
        clear_inputs();
        n_checks++;
        if ({bus.pc_out, bus.ifid_valid} !== {16'hFFFF, 1'b0}) begin
            n_fail++;
            $display("FAIL jump_target: got pc=%h v=%b want pc=ffff v=0", bus.pc_out, bus.ifid_valid);
        end
        tick();
        n_checks++;
        if ({bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid} !==
            {16'h0000, 16'h0FFF, 16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL jump_wrap: got pc=%h instr=%h pc1=%h v=%b want pc=0000 instr=0fff pc1=0000 v=1",
                     bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid);
        end
    endtask

    task automatic test_halt();
        halt_addr      = 6;
        bus.jmp        = 1'b1;
        bus.jmp_target = 16'h0004;
        tick();
        clear_inputs();
        tick();
        tick();
        tick();
        n_checks++;
        if ({bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid, bus.halted} !==
            {16'h0007, 16'hF123, 16'h0007, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL halt_capture: got pc=%h instr=%h pc1=%h v=%b h=%b want 0007 f123 0007 1 1",
                     bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid, bus.halted);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if ({bus.pc_out, bus.ifid_instr, bus.ifid_valid, bus.halted} !==
                {16'h0007, 16'h0000, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL halt_hold_%0d: got pc=%h instr=%h v=%b h=%b want 0007 0000 0 1",
                         k, bus.pc_out, bus.ifid_instr, bus.ifid_valid, bus.halted);
            end
        end
        bus.jmp        = 1'b1;
        bus.jmp_target = 16'h0020;
        tick();
        clear_inputs();
        n_checks++;
        if ({bus.pc_out, bus.ifid_valid, bus.halted} !== {16'h0020, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_exit_jump: got pc=%h v=%b h=%b want 0020 0 0",
                     bus.pc_out, bus.ifid_valid, bus.halted);
        end
        tick();
        n_checks++;
        if ({bus.pc_out, bus.ifid_instr, bus.ifid_valid} !== {16'h0021, 16'h1020, 1'b1}) begin
            n_fail++;
            $display("FAIL halt_resume_run: got pc=%h instr=%h v=%b want 0021 1020 1",
                     bus.pc_out, bus.ifid_instr, bus.ifid_valid);
        end
    endtask

    task automatic test_reset_in_halt();
        bus.jmp        = 1'b1;
        bus.jmp_target = 16'h0006;
        tick();
        clear_inputs();
        tick();
        bus.stall = 1'b1;
        tick();
        n_checks++;
        if ({bus.pc_out, bus.halted} !== {16'h0007, 1'b1}) begin
            n_fail++;
            $display("FAIL halt_stall_hold: got pc=%h h=%b want 0007 1", bus.pc_out, bus.halted);
        end
        // Assert reset between edges: outputs must clear without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid, bus.halted} !==
            {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got pc=%h instr=%h pc1=%h v=%b h=%b want 0000 0000 0000 0 0",
                     bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid, bus.halted);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if ({pf, ps, pr} !== 48'h0) begin
            n_fail++;
            $display("FAIL async_reset_perf: got %h %h %h want 0 0 0", pf, ps, pr);
        end
`endif
        clear_inputs();
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({bus.pc_out, bus.ifid_instr, bus.ifid_valid} !== {16'h0001, 16'h1000, 1'b1}) begin
            n_fail++;
            $display("FAIL first_edge_after_reset: got pc=%h instr=%h v=%b want 0001 1000 1",
                     bus.pc_out, bus.ifid_instr, bus.ifid_valid);
        end
    endtask

    // Randomized run against a behavioural model of the fetch rules.
    task automatic test_random();
        logic [15:0] m_pc, m_instr, m_pc1;
        logic        m_valid, m_halt;
        int          m_fetch, m_stall, m_flush;
        int          off, t;
        logic [15:0] w;

        rst = 1'b1;
        rnd_mode = 1'b1;
        halt_addr = -1;
        clear_inputs();
        tick();
        rst = 1'b0;
        m_pc = 16'h0000; m_instr = 16'h0000; m_pc1 = 16'h0000;
        m_valid = 1'b0; m_halt = 1'b0;
        m_fetch = 0; m_stall = 0; m_flush = 0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.br_taken   = ($urandom_range(0, 9) == 0);
            bus.jmp        = ($urandom_range(0, 12) == 0);
            bus.br_base    = 16'($urandom);
            bus.br_offset  = 8'($urandom);
            bus.jmp_target = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                           : 16'($urandom);

            if (bus.jmp || bus.br_taken) begin
                if (bus.jmp) begin
                    m_pc = bus.jmp_target;
                end else begin
                    off  = int'(bus.br_offset);
                    if (off > 127) off -= 256;
                    t    = ((int'(bus.br_base) + off) % 65536 + 65536) % 65536;
                    m_pc = 16'(t);
                end
                m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
                if (m_flush < 65535) m_flush++;
            end else if (bus.stall) begin
                if (m_stall < 65535) m_stall++;
            end else if (m_halt) begin
                m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0;
            end else begin
                w       = mem_word(m_pc, 1'b1, -1);
                m_instr = w;
                m_pc1   = 16'((int'(m_pc) + 1) % 65536);
                m_valid = 1'b1;
                if (w[15:12] == 4'hF) m_halt = 1'b1;
                m_pc    = m_pc1;
                if (m_fetch < 65535) m_fetch++;
            end

            tick();
            n_checks++;
            if ({bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid, bus.halted} !==
                {m_pc, m_instr, m_pc1, m_valid, m_halt}) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got pc=%h instr=%h pc1=%h v=%b h=%b want pc=%h instr=%h pc1=%h v=%b h=%b",
                         cyc, bus.pc_out, bus.ifid_instr, bus.ifid_pc_plus1, bus.ifid_valid, bus.halted,
                         m_pc, m_instr, m_pc1, m_valid, m_halt);
            end
`ifdef FETCH_PERF_CNT_EN
            n_checks++;
            if ({pf, ps, pr} !== {16'(m_fetch), 16'(m_stall), 16'(m_flush)}) begin
                n_fail++;
                $display("FAIL random_perf_%0d: got fetch=%0d stall=%0d flush=%0d want %0d %0d %0d",
                         cyc, pf, ps, pr, m_fetch, m_stall, m_flush);
            end
`endif
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_jump_wrap();
        test_halt();
        test_reset_in_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of InstructionMem.
- Owns the 16-bit word-addressed PC and drives it to the memory.
- Captures the returned instruction into the IF/ID pipeline register for the decoder.
- Handles stall, branch/jump redirect with flush, and a HALT state.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- DATA_W, 16, instruction and PC width.
- HALT_OPCODE, 4'hF, value of instr[15:12] that halts fetch.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- stall  in  1  hazard unit holds PC and IF/ID.
- br_taken  in  1  conditional branch resolved taken (from ID).
- br_base  in  16  PC+1 of the branching instruction.
- br_offset  in  8  signed word offset.
- jmp  in  1  unconditional jump (from ID).
- jmp_target  in  16  absolute jump address.
- instr_in  in  16  INSTR from InstructionMem.
- pc_out  out  16  PC to InstructionMem.
- ifid_instr  out  16  registered instruction.
- ifid_pc_plus1  out  16  registered PC+1 of ifid_instr.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch FSM is in HALT.

Behaviour:
- InstructionMem read is combinational with respect to pc_out. instr_in for pc_out is sampled at the same rising edge that advances PC.
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc_out=RESET_PC
  - ifid_instr=16'h0000 (NOP)
  - ifid_pc_plus1=16'h0000
  - ifid_valid=0
  - halted=0
  - FSM=RUN
- On deassertion, the first edge captures instr at RESET_PC.
- Priority per edge: jmp > br_taken > stall > HALT hold > normal.
- jmp: PC<=jmp_target; IF/ID flushed (instr=NOP, valid=0, pc_plus1=0); FSM=RUN.
- br_taken (no jmp): PC<=br_base + sign_extend(br_offset), modulo 2^16; flush and FSM=RUN as for jmp.
- Redirect overrides a simultaneous stall and a simultaneous HALT detection.
- stall (no redirect): PC, IF/ID and FSM all hold.
- Normal in RUN: PC<=PC+1, wrapping 16'hFFFF->16'h0000; IF/ID<={instr_in, PC+1, valid=1}.
- FSM has two states, RUN and HALT:
  - RUN->HALT on a normal capture where instr_in[15:12]==HALT_OPCODE. The HALT instruction itself is captured with valid=1.
  - In HALT: PC holds; the next non-stalled edge loads NOP with valid=0, which is then held; halted=1.
  - HALT->RUN only on redirect or reset.
- Branch target arithmetic: 16-bit, overflow and underflow wrap silently.
- One redirect latency: the target address appears on pc_out in the cycle after br_taken/jmp is sampled. The target instruction is valid in IF/ID one edge later.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds outputs perf_fetch_cnt, perf_stall_cnt and perf_flush_cnt, each 16 bits:
  - They count normal captures, stall edges and redirect edges respectively.
  - They saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds NOP_INSTR=16'h0000, HALT_OPCODE, DATA_W and the FSM state encoding (RUN=1'b0, HALT=1'b1).
- One sub-module, ifid_reg: the IF/ID register with load, hold and flush controls. The PC, next-PC mux and FSM stay in the top.

Test Plan:
- Reset then free-run, with memory at addr n returning 16'h1000+n:
  - pc_out steps 0,1,2,3.
  - ifid_instr lags one cycle: 16'h1000, 16'h1001.
  - ifid_valid=1 from the first edge.
- Stall high for 2 cycles at PC=3: pc_out stays 3 and ifid_instr stays 16'h1002 for 2 edges, then resumes at 4.
- br_taken with br_base=16'h0005, br_offset=8'hFC:
  - Next pc_out=16'h0001.
  - IF/ID flushed (valid=0, instr=0000).
  - A simultaneous stall is ignored.
- jmp with jmp_target=16'hFFFF, no stall: PC goes to FFFF, then wraps to 0000 on the next edge.
- Memory returns 16'hF123 at PC=6:
  - Captured with valid=1; halted=1 next.
  - pc_out frozen at 7; following IF/ID valid=0.
  - jmp to 16'h0020 resumes RUN.
- Assert rst mid-stall while in HALT: all outputs take reset values immediately, with no clock edge needed.
